cjb_alu_wb_stage: RTL and testbench
===================================

Name: cjb_alu_wb_stage

Overview:
- Downstream neighbour of the 8-bit ALU units (logic, arithmetic, shift). Consumes the selected ALU result and its CNVZ flags.
- Buffers result and destination-register tag in a 2-entry skid FIFO with a valid/ready handshake toward register-file write-back.
- Owns the architectural status register (CNVZ) and evaluates branch conditions from it.

Parameters:
- DATA_W, 8, width of the result datapath.
- DEST_W, 3, width of the destination register tag (8 GPRs).

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- ALU_Result  in  DATA_W  result from the ALU output mux.
- ALU_CNVZ  in  4  flags {C,N,V,Z} from the same ALU operation.
- ALU_Dest  in  DEST_W  destination register tag.
- ALU_Flag_WE  in  1  when 1, the accepted operation updates the status register.
- In_Valid  in  1  upstream has a valid operation.
- In_Ready  out  1  stage can accept; high when the FIFO is not full.
- WB_Valid  out  1  head entry valid toward the register file.
- WB_Data  out  DATA_W  head entry result.
- WB_Dest  out  DEST_W  head entry tag.
- WB_Ready  in  1  register file consumes the head this cycle.
- Cond_Sel  in  3  branch condition select.
- Status_CNVZ  out  4  current status register {C,N,V,Z}.
- Cond_True  out  1  selected condition evaluated on Status_CNVZ.

Behaviour:
- Reset (async on Resetn=0), all registered outputs cleared:
  - FIFO empty, WB_Valid=0, WB_Data=0, WB_Dest=0.
  - Status_CNVZ=4'b0000; In_Ready=1 once reset is released.
- Handshakes:
  - Accept when In_Valid & In_Ready.
  - Pop when WB_Valid & WB_Ready.
  - Inputs are sampled only on accept; while In_Ready=0 the upstream holds its values.
- FIFO state machine, states EMPTY/ONE/FULL:
  - EMPTY: accept -> ONE.
  - ONE: accept&~pop -> FULL; pop&~accept -> EMPTY; accept&pop -> ONE (new entry becomes head next cycle).
  - FULL: pop -> ONE; accept is impossible because In_Ready=0.
- Latency:
  - An accepted entry appears on WB_* the next cycle.
  - No combinational path from In_Valid or ALU_* to WB_*.
  - In_Ready is registered state only and does not depend combinationally on WB_Ready.
- Ordering: strict FIFO; WB_Data and WB_Dest hold stable while WB_Valid=1 and WB_Ready=0.
- Status register:
  - On accept with ALU_Flag_WE=1, Status_CNVZ <= ALU_CNVZ at that edge, independent of FIFO occupancy.
  - Otherwise Status_CNVZ holds.
- Cond_True is combinational from Status_CNVZ. Cond_Sel decode:
  - 000 always (1); 001 C; 010 N; 011 V.
  - 100 Z; 101 ~Z; 110 ~C; 111 ~N.
- Resetn asserted mid-transfer: FIFO contents are discarded and flags cleared; no partial write-back.

Optional Feature:
- Macro CJB_WB_SR_WRITE_EN.
- When defined, adds ports SR_Load (in, 1) and SR_Data (in, 4):
  - SR_Load=1 writes Status_CNVZ <= SR_Data at the edge.
  - SR_Load has priority over a simultaneous ALU flag update.
- When undefined, these ports do not exist and only accepted ALU operations with ALU_Flag_WE=1 modify the status register.

Decomposition:
- Shared package: CNVZ bit-index constants (C=3, N=2, V=1, Z=0), Cond_Sel encodings, FIFO state encoding.
- One sub-module is natural: cjb_cond_eval_v, combinational, Cond_Sel + CNVZ -> Cond_True. It is reused by the branch unit.

Test Plan:
- Reset: Resetn=0 mid-run with 2 entries queued -> WB_Valid=0, Status_CNVZ=0000, In_Ready=1 immediately after release.
- Single op: ALU_Result=8'hA5, Dest=3, CNVZ=0100, Flag_WE=1, WB_Ready=1 -> next cycle WB_Valid=1, WB_Data=A5, WB_Dest=3, Status_CNVZ=0100, Cond_Sel=010 gives Cond_True=1.
- Backpressure: WB_Ready=0, send 8'h11 then 8'h22 -> In_Ready=0 after the second accept; a third value is held. Release WB_Ready -> output order 11, 22, then the third value.
- Simultaneous accept and pop in state ONE -> occupancy stays ONE, no entry lost or duplicated, order preserved.
- Flag_WE=0 op with CNVZ=0001 after Status=1000 -> Status stays 1000; Cond_Sel=100 gives 0, 110 gives 0, 000 gives 1.
- With CJB_WB_SR_WRITE_EN: SR_Load=1, SR_Data=0010 in the same cycle as an accept with Flag_WE=1, CNVZ=0101 -> Status_CNVZ=0010.

Source files
------------

// File: rtl/cjb_alu_wb_stage_pkg.sv
// Shared definitions for the ALU write-back stage: CNVZ bit positions,
// branch condition encodings and the skid FIFO state encoding.
package cjb_alu_wb_stage_pkg;

    localparam int CNVZ_C = 3;
    localparam int CNVZ_N = 2;
    localparam int CNVZ_V = 1;
    localparam int CNVZ_Z = 0;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_C      = 3'b001;
    localparam logic [2:0] COND_N      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_Z      = 3'b100;
    localparam logic [2:0] COND_NZ     = 3'b101;
    localparam logic [2:0] COND_NC     = 3'b110;
    localparam logic [2:0] COND_NN     = 3'b111;

    localparam logic [1:0] FIFO_EMPTY = 2'd0;
    localparam logic [1:0] FIFO_ONE   = 2'd1;
    localparam logic [1:0] FIFO_FULL  = 2'd2;

endpackage

// File: rtl/cjb_alu_wb_stage_cond_eval.sv
// Combinational branch condition evaluator: Cond_Sel + {C,N,V,Z} -> true/false.
// Also instantiated by the branch unit.
module cjb_cond_eval_v
    import cjb_alu_wb_stage_pkg::*;
(
    input  logic [2:0] cond_sel,
    input  logic [3:0] cnvz,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            COND_ALWAYS: cond_true = 1'b1;
            COND_C:      cond_true = cnvz[CNVZ_C];
            COND_N:      cond_true = cnvz[CNVZ_N];
            COND_V:      cond_true = cnvz[CNVZ_V];
            COND_Z:      cond_true = cnvz[CNVZ_Z];
            COND_NZ:     cond_true = ~cnvz[CNVZ_Z];
            COND_NC:     cond_true = ~cnvz[CNVZ_C];
            COND_NN:     cond_true = ~cnvz[CNVZ_N];
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cjb_alu_wb_stage.sv
// ALU write-back stage: 2-entry skid FIFO toward the register file, CNVZ status
// register and branch condition output. Optional macro CJB_WB_SR_WRITE_EN adds a
// direct status-register load port (SR_Load/SR_Data) with priority over ALU flags.
module cjb_alu_wb_stage
    import cjb_alu_wb_stage_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEST_W = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic [3:0]        ALU_CNVZ,
    input  logic [DEST_W-1:0] ALU_Dest,
    input  logic              ALU_Flag_WE,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic              WB_Valid,
    output logic [DATA_W-1:0] WB_Data,
    output logic [DEST_W-1:0] WB_Dest,
    input  logic              WB_Ready,
    input  logic [2:0]        Cond_Sel,
    output logic [3:0]        Status_CNVZ,
    output logic              Cond_True,
`ifdef CJB_WB_SR_WRITE_EN
    input  logic              SR_Load,
    input  logic [3:0]        SR_Data,
`endif
    output logic [1:0]        fifo_state
);

    // Handshake: an item moves only on a cycle where valid and ready are both
    // high at the rising edge; a source holds its payload while valid & ~ready.
    logic              accept;
    logic              pop;
    logic [1:0]        state;
    logic [DATA_W-1:0] tail_data;
    logic [DEST_W-1:0] tail_dest;

    assign accept     = In_Valid & In_Ready;
    assign pop        = WB_Valid & WB_Ready;
    assign In_Ready   = (state != FIFO_FULL);
    assign WB_Valid   = (state != FIFO_EMPTY);
    assign fifo_state = state;

    // WB_Data/WB_Dest are the head register itself; tail is only used when FULL.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= FIFO_EMPTY;
            WB_Data   <= '0;
            WB_Dest   <= '0;
            tail_data <= '0;
            tail_dest <= '0;
        end else begin
            case (state)
                FIFO_EMPTY: begin
                    if (accept) begin
                        WB_Data <= ALU_Result;
                        WB_Dest <= ALU_Dest;
                        state   <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (accept && pop) begin
                        WB_Data <= ALU_Result;
                        WB_Dest <= ALU_Dest;
                    end else if (accept) begin
                        tail_data <= ALU_Result;
                        tail_dest <= ALU_Dest;
                        state     <= FIFO_FULL;
                    end else if (pop) begin
                        state <= FIFO_EMPTY;
                    end
                end
                FIFO_FULL: begin
                    if (pop) begin
                        WB_Data <= tail_data;
                        WB_Dest <= tail_dest;
                        state   <= FIFO_ONE;
                    end
                end
                default: state <= FIFO_EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Status_CNVZ <= 4'b0000;
`ifdef CJB_WB_SR_WRITE_EN
        end else if (SR_Load) begin
            Status_CNVZ <= SR_Data;
`endif
        end else if (accept && ALU_Flag_WE) begin
            Status_CNVZ <= ALU_CNVZ;
        end
    end

    cjb_cond_eval_v u_cond_eval (
        .cond_sel  (Cond_Sel),
        .cnvz      (Status_CNVZ),
        .cond_true (Cond_True)
    );

endmodule

// File: tb/tb_cjb_alu_wb_stage.sv
// Self-checking bench for cjb_alu_wb_stage: vector table for flags/conditions,
// hand-written sequences for backpressure, accept+pop, and mid-run reset.
module tb_cjb_alu_wb_stage;
    import cjb_alu_wb_stage_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEST_W = 3;
    localparam int EW     = DATA_W + DEST_W;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b0;
    logic [DATA_W-1:0] ALU_Result = '0;
    logic [3:0]        ALU_CNVZ = '0;
    logic [DEST_W-1:0] ALU_Dest = '0;
    logic              ALU_Flag_WE = 1'b0;
    logic              In_Valid = 1'b0;
    logic              In_Ready;
    logic              WB_Valid;
    logic [DATA_W-1:0] WB_Data;
    logic [DEST_W-1:0] WB_Dest;
    logic              WB_Ready = 1'b0;
    logic [2:0]        Cond_Sel = '0;
    logic [3:0]        Status_CNVZ;
    logic              Cond_True;
    logic [1:0]        fifo_state;
`ifdef CJB_WB_SR_WRITE_EN
    logic              SR_Load = 1'b0;
    logic [3:0]        SR_Data = '0;
`endif

    logic [EW-1:0] exp_q[$];
    int vec_count = 0;
    int miscount  = 0;

    typedef struct {
        logic [7:0] result;
        logic [3:0] cnvz;
        logic [2:0] dest;
        logic       flag_we;
        logic [2:0] cond_sel;
        logic [3:0] exp_status;
        logic       exp_cond;
    } vec_t;

    vec_t vecs[10];

    cjb_alu_wb_stage #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .ALU_Result  (ALU_Result),
        .ALU_CNVZ    (ALU_CNVZ),
        .ALU_Dest    (ALU_Dest),
        .ALU_Flag_WE (ALU_Flag_WE),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .WB_Valid    (WB_Valid),
        .WB_Data     (WB_Data),
        .WB_Dest     (WB_Dest),
        .WB_Ready    (WB_Ready),
        .Cond_Sel    (Cond_Sel),
        .Status_CNVZ (Status_CNVZ),
        .Cond_True   (Cond_True),
`ifdef CJB_WB_SR_WRITE_EN
        .SR_Load     (SR_Load),
        .SR_Data     (SR_Data),
`endif
        .fifo_state  (fifo_state)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscount++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: presents one op and holds it until accepted (bounded)
    task automatic send(input logic [7:0] r, input logic [3:0] f, input logic [2:0] d, input logic we);
        int waited;
        waited      = 0;
        ALU_Result  = r;
        ALU_CNVZ    = f;
        ALU_Dest    = d;
        ALU_Flag_WE = we;
        In_Valid    = 1'b1;
        while (!In_Ready && waited < 40) begin
            tick();
            waited++;
        end
        if (!In_Ready) begin
            check("in_ready_timeout", 32'(In_Ready), 32'd1);
            In_Valid = 1'b0;
            return;
        end
        exp_q.push_back({d, r});
        tick();
        In_Valid    = 1'b0;
        ALU_Flag_WE = 1'b0;
    endtask

    // scoreboard: compare each popped head against the expected queue
    always @(negedge Clock) begin
        if (Resetn && WB_Valid && WB_Ready) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miscount++;
                $display("FAIL wb_unexpected: got %0h, want no entry at %0t", {WB_Dest, WB_Data}, $time);
            end else begin
                check("wb_entry", 32'({WB_Dest, WB_Data}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 4'b0100, 3'd3, 1'b1, COND_N,      4'b0100, 1'b1};
        vecs[1] = '{8'h3C, 4'b1000, 3'd5, 1'b1, COND_C,      4'b1000, 1'b1};
        vecs[2] = '{8'h77, 4'b0001, 3'd1, 1'b0, COND_Z,      4'b1000, 1'b0};
        vecs[3] = '{8'h00, 4'b0001, 3'd0, 1'b0, COND_NC,     4'b1000, 1'b0};
        vecs[4] = '{8'hFF, 4'b0001, 3'd7, 1'b0, COND_ALWAYS, 4'b1000, 1'b1};
        vecs[5] = '{8'h80, 4'b0011, 3'd2, 1'b1, COND_V,      4'b0011, 1'b1};
        vecs[6] = '{8'h01, 4'b0110, 3'd4, 1'b1, COND_NZ,     4'b0110, 1'b1};
        vecs[7] = '{8'h42, 4'b0111, 3'd6, 1'b1, COND_NN,     4'b0111, 1'b0};
        vecs[8] = '{8'h99, 4'b1001, 3'd3, 1'b1, COND_Z,      4'b1001, 1'b1};
        vecs[9] = '{8'h5A, 4'b0000, 3'd2, 1'b1, COND_NC,     4'b0000, 1'b1};

        // reset state
        #12;
        check("rst_wb_valid", 32'(WB_Valid), 32'd0);
        check("rst_wb_data", 32'(WB_Data), 32'd0);
        check("rst_wb_dest", 32'(WB_Dest), 32'd0);
        check("rst_status", 32'(Status_CNVZ), 32'd0);
        check("rst_fifo_state", 32'(fifo_state), 32'(FIFO_EMPTY));
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        check("rst_in_ready", 32'(In_Ready), 32'd1);

        // vector table with write-back always ready
        WB_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Cond_Sel = vecs[i].cond_sel;
            send(vecs[i].result, vecs[i].cnvz, vecs[i].dest, vecs[i].flag_we);
            check("vec_status", 32'(Status_CNVZ), 32'(vecs[i].exp_status));
            check("vec_cond", 32'(Cond_True), 32'(vecs[i].exp_cond));
        end
        repeat (3) tick();
        check("vec_drained", 32'(exp_q.size()), 32'd0);
        check("vec_empty_state", 32'(fifo_state), 32'(FIFO_EMPTY));

        // backpressure: two entries fill the FIFO, third is held upstream
        WB_Ready = 1'b0;
        send(8'h11, 4'b1111, 3'd1, 1'b0);
        send(8'h22, 4'b1111, 3'd2, 1'b0);
        check("bp_in_ready", 32'(In_Ready), 32'd0);
        check("bp_full", 32'(fifo_state), 32'(FIFO_FULL));
        check("bp_flags_untouched", 32'(Status_CNVZ), 32'd0);
        fork
            send(8'h33, 4'b0000, 3'd3, 1'b0);
            begin
                tick();
                tick();
                check("bp_hold_data", 32'(WB_Data), 32'h11);
                check("bp_hold_dest", 32'(WB_Dest), 32'd1);
                check("bp_still_blocked", 32'(In_Ready), 32'd0);
                WB_Ready = 1'b1;
            end
        join
        repeat (4) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // accept and pop in the same cycle while in ONE
        send(8'hAA, 4'b0000, 3'd5, 1'b0);
        check("ap_one_first", 32'(fifo_state), 32'(FIFO_ONE));
        send(8'hBB, 4'b0000, 3'd6, 1'b0);
        check("ap_one_after", 32'(fifo_state), 32'(FIFO_ONE));
        check("ap_head", 32'(WB_Data), 32'hBB);
        tick();
        check("ap_empty", 32'(fifo_state), 32'(FIFO_EMPTY));
        check("ap_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-transfer with two entries queued
        WB_Ready = 1'b0;
        send(8'hC1, 4'b1000, 3'd1, 1'b1);
        send(8'hC2, 4'b0110, 3'd2, 1'b1);
        check("mr_status_before", 32'(Status_CNVZ), 32'b0110);
        #2;
        Resetn = 1'b0;
        #1;
        exp_q.delete();
        check("mr_wb_valid", 32'(WB_Valid), 32'd0);
        check("mr_status", 32'(Status_CNVZ), 32'd0);
        check("mr_wb_data", 32'(WB_Data), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        #1;
        check("mr_in_ready", 32'(In_Ready), 32'd1);
        check("mr_state", 32'(fifo_state), 32'(FIFO_EMPTY));
        WB_Ready = 1'b1;
        repeat (3) tick();
        check("mr_no_writeback", 32'(WB_Valid), 32'd0);

`ifdef CJB_WB_SR_WRITE_EN
        // direct load wins over a simultaneous ALU flag update
        SR_Load = 1'b1;
        SR_Data = 4'b0010;
        send(8'h5C, 4'b0101, 3'd4, 1'b1);
        SR_Load = 1'b0;
        check("sr_priority", 32'(Status_CNVZ), 32'b0010);
        SR_Load = 1'b1;
        SR_Data = 4'b1001;
        tick();
        SR_Load = 1'b0;
        check("sr_load_only", 32'(Status_CNVZ), 32'b1001);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscount);
        $finish;
    end

endmodule
